isp_ae_ctrl: RTL
================

Name: isp_ae_ctrl

Overview:
Auto-exposure controller that drives the `gain` input of the digital-gain stage (4.4 fixed point).
- Per frame, accumulates active raw pixels, computes the mean with a serial divider during vertical blanking, and steps the gain toward a programmable target.
- Sits beside the raw pipeline: taps the digital-gain output stream; its gain output feeds the digital-gain stage for the next frame.

Parameters:
BITS, 8, raw pixel width
WIDTH, 1280, active pixels per line
HEIGHT, 960, active lines per frame
GAIN_INIT, 8'h10, reset gain (1.0 in 4.4)
GAIN_MIN, 8'h08, lower gain clamp (0.5)
GAIN_MAX, 8'hF0, upper gain clamp (15.0)
STEP, 8'h01, gain increment/decrement per frame

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
in_href  in  1  line valid
in_vsync  in  1  frame valid; high during frame
in_raw  in  BITS  raw pixel
ae_en  in  1  1 = automatic gain, 0 = manual
manual_gain  in  8  gain used when ae_en=0 (4.4)
target  in  BITS  target mean
tolerance  in  BITS  dead band half-width
gain  out  8  gain to the digital-gain stage (4.4)
mean  out  BITS  last computed frame mean
mean_valid  out  1  one-cycle pulse when mean updates

Behaviour:
Clock, reset and reset values:
- One clock (pclk). rst_n is asynchronous and active-low.
- Reset: gain register=GAIN_INIT, mean=0, mean_valid=0, accumulators=0, state=ACCUM.
- Reset mid-DIV aborts the division; no mean_valid.

Widths:
- CNT_W=$clog2(WIDTH*HEIGHT+1); SUM_W=BITS+CNT_W.
- Accumulators saturate at all-ones; no wrap.

Accumulation:
- When in_href&&in_vsync, in the enabled window: sum+=in_raw, cnt+=1.

Frame end:
- vsync_d is in_vsync registered.
- Frame end is the first cycle with vsync_d=1 and in_vsync=0 (cycle T).
- At T: sum/cnt are copied into divider registers and the accumulators clear.
- Pixels of the next frame accumulate independently of the divider.

FSM:
- ACCUM: idle, waiting for frame end. Frame end -> DIV, or -> ADJ with quotient=0 and skip flag set if cnt=0.
- DIV: restoring division, one quotient bit per cycle, SUM_W cycles, then -> ADJ.
- ADJ, one cycle:
  - Unless skip: mean <= quotient saturated to {BITS{1}}; mean_valid=1.
  - If ae_en && !skip, update the gain register (below).
  - -> ACCUM.
- Frame end while in DIV/ADJ (blanking shorter than SUM_W+2 cycles): that frame's statistics are dropped and its accumulators still clear.

Timing:
- mean and mean_valid appear at T+SUM_W+1.
- gain updates in the same cycle as mean.
- cnt=0 frame: no mean_valid, gain held.

Gain update, 9-bit arithmetic:
- lo=max(target-tolerance,0); hi=min(target+tolerance,2^BITS-1).
- mean<lo: g=min(g+STEP,GAIN_MAX).
- mean>hi: g=max(g-STEP,GAIN_MIN).
- Otherwise hold.

Manual mode:
- ae_en=0: gain output = manual_gain combinationally, and the gain register loads manual_gain every cycle. Re-enabling therefore starts from the manual value.
- ae_en toggled during DIV: division completes and mean updates; the adjustment uses ae_en sampled in ADJ.

Optional Feature:
ISP_AE_WINDOW_EN:
- Defined: adds inputs win_x0, win_x1, win_y0, win_y1 (16 bits each) plus column and row counters.
  - Column counter resets on href low; row counter increments on href falling edge and resets on vsync low.
  - A pixel accumulates only if x0<=col<=x1 and y0<=row<=y1, inclusive.
  - Windows are sampled at frame start (vsync rising edge).
  - x0>x1 or y0>y1 gives an empty window, i.e. cnt=0 behaviour.
- Undefined: the whole frame accumulates and no window ports exist.

Test Plan:
1. WIDTH=8, HEIGHT=4, all pixels 0x40, target=0x80, tolerance=4, ae_en=1 -> mean=0x40, mean_valid pulses at T+SUM_W+1, gain 0x10->0x11.
2. Same frame, pixels 0x82 -> mean=0x82, inside the dead band, gain held at 0x10.
3. 250 consecutive frames of 0xFF, target=0x20 -> gain decrements by 1 per frame and clamps at GAIN_MIN=0x08; repeat with 0x00 -> clamps at GAIN_MAX=0xF0.
4. Frame with vsync high and href never asserted -> no mean_valid, gain unchanged.
5. ae_en=0, manual_gain=0x35 -> gain=0x35 immediately; re-enable, dark frame -> gain=0x36.
6. Frame end repeated within 5 cycles during DIV -> no mean_valid for the second frame; assert rst_n low mid-DIV -> gain=GAIN_INIT, mean=0, no pulse.

Source files
------------

// File: rtl/isp_ae_ctrl.sv
// Auto-exposure controller: per-frame pixel mean via a serial restoring divider in blanking,
// then a clamped gain step toward a target. Define ISP_AE_WINDOW_EN to add a metering window.
module isp_ae_ctrl #(
  parameter int         BITS      = 8,
  parameter int         WIDTH     = 1280,
  parameter int         HEIGHT    = 960,
  parameter logic [7:0] GAIN_INIT = 8'h10,
  parameter logic [7:0] GAIN_MIN  = 8'h08,
  parameter logic [7:0] GAIN_MAX  = 8'hF0,
  parameter logic [7:0] STEP      = 8'h01
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_raw,
  input  logic            ae_en,
  input  logic [7:0]      manual_gain,
  input  logic [BITS-1:0] target,
  input  logic [BITS-1:0] tolerance,
`ifdef ISP_AE_WINDOW_EN
  input  logic [15:0]     win_x0,
  input  logic [15:0]     win_x1,
  input  logic [15:0]     win_y0,
  input  logic [15:0]     win_y1,
`endif
  output logic [7:0]      gain,
  output logic [BITS-1:0] mean,
  output logic            mean_valid
);

  localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);
  localparam int SUM_W = BITS + CNT_W;
  localparam int BC_W  = $clog2(SUM_W);

  typedef enum logic [1:0] {ACCUM, DIV, ADJ} state_t;

  state_t            state_q, state_d;
  logic              vsync_q;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  dvd_q, dvd_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic              skip_q, skip_d;
  logic [BITS-1:0]   mean_q, mean_d;
  logic              mean_valid_q, mean_valid_d;
  logic [7:0]        gain_q, gain_d;

  logic              frame_end;
  logic              in_window;
  logic              pix_take;
  logic [SUM_W:0]    sum_add;

  assign frame_end = vsync_q && !in_vsync;
  assign pix_take  = in_href && in_vsync && in_window;
  assign sum_add   = {1'b0, sum_q} + (SUM_W + 1)'(in_raw);

`ifdef ISP_AE_WINDOW_EN
  logic        href_q;
  logic [15:0] col_q, row_q;
  logic [15:0] wx0_q, wx1_q, wy0_q, wy1_q;
  logic [15:0] wx0, wx1, wy0, wy1;
  logic        vsync_rise;

  assign vsync_rise = in_vsync && !vsync_q;
  // The first line can start on the very cycle vsync rises, so bypass the window latch then.
  assign wx0 = vsync_rise ? win_x0 : wx0_q;
  assign wx1 = vsync_rise ? win_x1 : wx1_q;
  assign wy0 = vsync_rise ? win_y0 : wy0_q;
  assign wy1 = vsync_rise ? win_y1 : wy1_q;
  assign in_window = (col_q >= wx0) && (col_q <= wx1) && (row_q >= wy0) && (row_q <= wy1);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      wx0_q  <= '0;
      wx1_q  <= '0;
      wy0_q  <= '0;
      wy1_q  <= '0;
    end else begin
      href_q <= in_href;
      col_q  <= in_href ? col_q + 16'd1 : '0;
      if (!in_vsync)               row_q <= '0;
      else if (href_q && !in_href) row_q <= row_q + 16'd1;
      if (vsync_rise) begin
        wx0_q <= win_x0;
        wx1_q <= win_x1;
        wy0_q <= win_y0;
        wy1_q <= win_y1;
      end
    end
  end
`else
  assign in_window = 1'b1;
`endif

  // Statistics accumulators; they clear at every frame end, whatever the divider is doing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (frame_end) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (pix_take) begin
      sum_d = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Restoring divider: quotient bits shift into the low end of the dividend register.
  logic [CNT_W:0]   rem_trial;
  logic [CNT_W-1:0] rem_sub;
  logic             q_bit;

  assign rem_trial = {rem_q, dvd_q[SUM_W-1]};
  assign q_bit     = rem_trial >= {1'b0, dvs_q};
  assign rem_sub   = rem_trial[CNT_W-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    skip_d  = skip_q;
    case (state_q)
      ACCUM: begin
        if (frame_end) begin
          dvs_d = cnt_q;
          rem_d = '0;
          bit_d = BC_W'(SUM_W - 1);
          if (cnt_q == '0) begin
            skip_d  = 1'b1;
            dvd_d   = '0;
            state_d = ADJ;
          end else begin
            skip_d  = 1'b0;
            dvd_d   = sum_q;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        dvd_d = {dvd_q[SUM_W-2:0], q_bit};
        rem_d = q_bit ? rem_sub : rem_trial[CNT_W-1:0];
        if (bit_q == '0) state_d = ADJ;
        else             bit_d   = bit_q - BC_W'(1);
      end
      ADJ:     state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Dead band and gain step, all in one-bit-wider arithmetic so under/overflow is visible.
  logic [BITS-1:0] quo_sat;
  logic [BITS:0]   t_sum, t_dif;
  logic [BITS-1:0] lo, hi;
  logic [8:0]      g_up, g_dn;
  logic [7:0]      gain_up, gain_dn;
  logic            adj_fire;

  assign quo_sat  = (|dvd_q[SUM_W-1:BITS]) ? '1 : dvd_q[BITS-1:0];
  assign t_sum    = {1'b0, target} + {1'b0, tolerance};
  assign t_dif    = {1'b0, target} - {1'b0, tolerance};
  assign lo       = t_dif[BITS] ? '0 : t_dif[BITS-1:0];
  assign hi       = t_sum[BITS] ? '1 : t_sum[BITS-1:0];
  assign g_up     = {1'b0, gain_q} + {1'b0, STEP};
  assign g_dn     = {1'b0, gain_q} - {1'b0, STEP};
  assign gain_up  = (g_up > {1'b0, GAIN_MAX}) ? GAIN_MAX : g_up[7:0];
  assign gain_dn  = (g_dn[8] || (g_dn[7:0] < GAIN_MIN)) ? GAIN_MIN : g_dn[7:0];
  assign adj_fire = (state_q == ADJ) && !skip_q;

  always_comb begin
    mean_d       = adj_fire ? quo_sat : mean_q;
    mean_valid_d = adj_fire;
    gain_d       = gain_q;
    if (!ae_en) begin
      gain_d = manual_gain;
    end else if (adj_fire) begin
      if (quo_sat < lo)      gain_d = gain_up;
      else if (quo_sat > hi) gain_d = gain_dn;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    // NOTE: the divider datapath is reset too, so a reset mid-division leaves no stale result.
    if (!rst_n) begin
      state_q      <= ACCUM;
      vsync_q      <= 1'b0;
      sum_q        <= '0;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      bit_q        <= '0;
      skip_q       <= 1'b0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      gain_q       <= GAIN_INIT;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      vsync_q      <= in_vsync;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      bit_q        <= bit_d;
      skip_q       <= skip_d;
      mean_q       <= mean_d;
      mean_valid_q <= mean_valid_d;
      gain_q       <= gain_d;
    end
  end

  assign gain       = ae_en ? gain_q : manual_gain;
  assign mean       = mean_q;
  assign mean_valid = mean_valid_q;

endmodule
